control_pipe: RTL and testbench

//  Downstream receiver of the decode-stage control bundle produced by controlunit.

---
 rtl/control_pipe_pkg.sv | 44 ++++
 rtl/control_pipe_if.sv | 74 +++++++
 rtl/pipe_stage_reg.sv | 26 ++
 rtl/control_pipe.sv | 152 +++++++++++++++
 tb/tb_control_pipe.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pipe_pkg.sv
// Shared types for the control pipeline: per-stage control payloads,
// their bubble encodings and the ALU operation codes.
package control_pipe_pkg;

  localparam int unsigned ALU_W = 3;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALU_W-1:0] ALU_XOR  = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SLT  = 3'b101;
  localparam logic [ALU_W-1:0] ALU_PASS = 3'b110;
  localparam logic [ALU_W-1:0] ALU_IMM  = 3'b111;

  // Control consumed in EX and carried onward.
  typedef struct packed {
    logic             data2_sel;
    logic [ALU_W-1:0] alu_ctrl;
    logic             reg_we;
    logic             mem_we;
    logic             res_sel;
    logic             out_flag;
  } ctrl_e_t;

  // Control consumed in MEM and carried onward.
  typedef struct packed {
    logic reg_we;
    logic mem_we;
    logic res_sel;
    logic out_flag;
  } ctrl_m_t;

  // Control consumed in WB.
  typedef struct packed {
    logic reg_we;
    logic res_sel;
  } ctrl_w_t;

  localparam ctrl_e_t BUBBLE_E = '0;
  localparam ctrl_m_t BUBBLE_M = '0;
  localparam ctrl_w_t BUBBLE_W = '0;

endpackage

// File: rtl/control_pipe_if.sv
// Bus between the decode stage / datapath and control_pipe.
//   master: drives the D-stage bundle plus stallIn/flushIn, observes stage control.
//   slave : control_pipe side; drives stallD, E/M/WB control and retiredCount.
interface control_pipe_if
  import control_pipe_pkg::*;
#(
  parameter int unsigned REGADDRWIDTH = 4,
  parameter int unsigned CNTWIDTH     = 16
);

  // D-stage bundle and global controls
  logic                    writeEnableDD;
  logic                    writeDataEnableMD;
  logic                    resultSelectorWBD;
  logic                    data2SelectorED;
  logic [ALU_W-1:0]        aluControlED;
  logic                    outFlag;
  logic                    validD;
  logic [REGADDRWIDTH-1:0] rdD;
  logic [REGADDRWIDTH-1:0] rs1D;
  logic [REGADDRWIDTH-1:0] rs2D;
  logic                    stallIn;
  logic                    flushIn;

  // Hazard stall back to fetch/decode
  logic                    stallD;

  // E stage
  logic                    data2SelectorE;
  logic [ALU_W-1:0]        aluControlE;
  logic                    writeEnableE;
  logic                    writeDataEnableME;
  logic                    resultSelectorWBE;
  logic                    outFlagE;
  logic [REGADDRWIDTH-1:0] rdE;
  logic                    validE;

  // M stage
  logic                    writeEnableM;
  logic                    writeDataEnableM;
  logic                    resultSelectorWBM;
  logic                    outFlagM;
  logic [REGADDRWIDTH-1:0] rdM;
  logic                    validM;

  // WB stage
  logic                    writeEnableW;
  logic                    resultSelectorW;
  logic [REGADDRWIDTH-1:0] rdW;
  logic                    validW;

  logic [CNTWIDTH-1:0]     retiredCount;

  modport master (
    output writeEnableDD, writeDataEnableMD, resultSelectorWBD, data2SelectorED,
           aluControlED, outFlag, validD, rdD, rs1D, rs2D, stallIn, flushIn,
    input  stallD,
           data2SelectorE, aluControlE, writeEnableE, writeDataEnableME,
           resultSelectorWBE, outFlagE, rdE, validE,
           writeEnableM, writeDataEnableM, resultSelectorWBM, outFlagM, rdM, validM,
           writeEnableW, resultSelectorW, rdW, validW, retiredCount
  );

  modport slave (
    input  writeEnableDD, writeDataEnableMD, resultSelectorWBD, data2SelectorED,
           aluControlED, outFlag, validD, rdD, rs1D, rs2D, stallIn, flushIn,
    output stallD,
           data2SelectorE, aluControlE, writeEnableE, writeDataEnableME,
           resultSelectorWBE, outFlagE, rdE, validE,
           writeEnableM, writeDataEnableM, resultSelectorWBM, outFlagM, rdM, validM,
           writeEnableW, resultSelectorW, rdW, validW, retiredCount
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register for one stage payload.
//   clk, rst_n : clock, async active-low reset (loads bubble)
//   en         : 1 = stage advances, 0 = stage holds
//   clr        : with en, load a bubble instead of d
//   d, q       : payload in / registered payload out
// The bubble encoding of every stage payload is all-zero.
module pipe_stage_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Carries the decode-stage control bundle through ID/EX, EX/MEM and MEM/WB,
// applying global stall, branch flush and load-use bubble insertion, and
// counts retired instructions.
//   clk, rst : clock, async active-low reset
//   bus      : control_pipe_if.slave (D bundle in, stallD and E/M/WB control out)
// Build option: HAZARD_DETECT_EN enables load-use hazard detection; without it
// stallD is tied low and rs1D/rs2D are ignored.
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int unsigned REGADDRWIDTH = 4,
  parameter int unsigned CNTWIDTH     = 16
) (
  input logic           clk,
  input logic           rst,
  control_pipe_if.slave bus
);

  typedef struct packed {
    logic                    valid;
    logic [REGADDRWIDTH-1:0] rd;
    ctrl_e_t                 ctrl;
  } stage_e_t;

  typedef struct packed {
    logic                    valid;
    logic [REGADDRWIDTH-1:0] rd;
    ctrl_m_t                 ctrl;
  } stage_m_t;

  typedef struct packed {
    logic                    valid;
    logic [REGADDRWIDTH-1:0] rd;
    ctrl_w_t                 ctrl;
  } stage_w_t;

  stage_e_t            e_d, e_q;
  stage_m_t            m_d, m_q;
  stage_w_t            w_d, w_q;
  logic                adv_c;
  logic                hazard_c;
  logic                kill_e_c;
  logic [CNTWIDTH-1:0] retired_q;

  assign adv_c = ~bus.stallIn;

  // Load in E whose destination feeds the D instruction: insert one bubble.
`ifdef HAZARD_DETECT_EN
  assign hazard_c = e_q.valid & e_q.ctrl.reg_we & e_q.ctrl.res_sel & bus.validD
                  & ((e_q.rd == bus.rs1D) | (e_q.rd == bus.rs2D));
`else
  logic unused_rs;
  assign unused_rs = ^{bus.rs1D, bus.rs2D};
  assign hazard_c  = 1'b0;
`endif

  assign kill_e_c   = bus.flushIn | hazard_c;
  assign bus.stallD = hazard_c & ~bus.stallIn & ~bus.flushIn;

  // D bundle into E; don't-care bits are masked so no X leaks downstream.
  always_comb begin
    e_d                = '0;
    e_d.ctrl           = BUBBLE_E;
    e_d.valid          = bus.validD;
    e_d.rd             = bus.rdD;
    e_d.ctrl.data2_sel = bus.data2SelectorED & bus.validD;
    e_d.ctrl.alu_ctrl  = bus.aluControlED;
    e_d.ctrl.reg_we    = bus.writeEnableDD;
    e_d.ctrl.mem_we    = bus.writeDataEnableMD;
    e_d.ctrl.res_sel   = bus.resultSelectorWBD & bus.writeEnableDD;
    e_d.ctrl.out_flag  = bus.outFlag;
  end

  // E to M and M to WB: drop control already consumed by the earlier stage.
  always_comb begin
    m_d               = '0;
    m_d.ctrl          = BUBBLE_M;
    m_d.valid         = e_q.valid;
    m_d.rd            = e_q.rd;
    m_d.ctrl.reg_we   = e_q.ctrl.reg_we;
    m_d.ctrl.mem_we   = e_q.ctrl.mem_we;
    m_d.ctrl.res_sel  = e_q.ctrl.res_sel;
    m_d.ctrl.out_flag = e_q.ctrl.out_flag;

    w_d               = '0;
    w_d.ctrl          = BUBBLE_W;
    w_d.valid         = m_q.valid;
    w_d.rd            = m_q.rd;
    w_d.ctrl.reg_we   = m_q.ctrl.reg_we;
    w_d.ctrl.res_sel  = m_q.ctrl.res_sel;
  end

  pipe_stage_reg #(.T(stage_e_t)) u_stage_e (
    .clk   (clk),
    .rst_n (rst),
    .en    (adv_c),
    .clr   (kill_e_c),
    .d     (e_d),
    .q     (e_q)
  );

  pipe_stage_reg #(.T(stage_m_t)) u_stage_m (
    .clk   (clk),
    .rst_n (rst),
    .en    (adv_c),
    .clr   (1'b0),
    .d     (m_d),
    .q     (m_q)
  );

  pipe_stage_reg #(.T(stage_w_t)) u_stage_w (
    .clk   (clk),
    .rst_n (rst),
    .en    (adv_c),
    .clr   (1'b0),
    .d     (w_d),
    .q     (w_q)
  );

  // Retirement counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else if (adv_c && w_q.valid) begin
      retired_q <= retired_q + CNTWIDTH'(1);
    end
  end

  assign bus.data2SelectorE    = e_q.ctrl.data2_sel;
  assign bus.aluControlE       = e_q.ctrl.alu_ctrl;
  assign bus.writeEnableE      = e_q.ctrl.reg_we;
  assign bus.writeDataEnableME = e_q.ctrl.mem_we;
  assign bus.resultSelectorWBE = e_q.ctrl.res_sel;
  assign bus.outFlagE          = e_q.ctrl.out_flag;
  assign bus.rdE               = e_q.rd;
  assign bus.validE            = e_q.valid;

  assign bus.writeEnableM      = m_q.ctrl.reg_we;
  assign bus.writeDataEnableM  = m_q.ctrl.mem_we;
  assign bus.resultSelectorWBM = m_q.ctrl.res_sel;
  assign bus.outFlagM          = m_q.ctrl.out_flag;
  assign bus.rdM               = m_q.rd;
  assign bus.validM            = m_q.valid;

  assign bus.writeEnableW      = w_q.ctrl.reg_we;
  assign bus.resultSelectorW   = w_q.ctrl.res_sel;
  assign bus.rdW               = w_q.rd;
  assign bus.validW            = w_q.valid;

  assign bus.retiredCount      = retired_q;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe (CNTWIDTH=4 so the counter wraps quickly).
module tb_control_pipe;

  localparam int unsigned RA_W  = 4;
  localparam int unsigned CNT_W = 4;
`ifdef HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  typedef struct packed {
    logic            we;
    logic            rs;
    logic [RA_W-1:0] rd;
  } wexp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  control_pipe_if #(.REGADDRWIDTH(RA_W), .CNTWIDTH(CNT_W)) bus ();

  control_pipe #(.REGADDRWIDTH(RA_W), .CNTWIDTH(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wexp_t           sb_q[$];
  int              n_chk  = 0;
  int              n_fail = 0;
  logic [CNT_W-1:0] exp_cnt;
  bit              mon_en;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] e_vec();
    return {bus.data2SelectorE, bus.aluControlE, bus.writeEnableE, bus.writeDataEnableME,
            bus.resultSelectorWBE, bus.outFlagE, bus.rdE, bus.validE};
  endfunction

  function automatic logic [8:0] m_vec();
    return {bus.writeEnableM, bus.writeDataEnableM, bus.resultSelectorWBM, bus.outFlagM,
            bus.rdM, bus.validM};
  endfunction

  function automatic logic [6:0] w_vec();
    return {bus.writeEnableW, bus.resultSelectorW, bus.rdW, bus.validW};
  endfunction

  function automatic logic [33:0] all_vec();
    return {bus.stallD, e_vec(), m_vec(), w_vec(), bus.retiredCount};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive the D bundle; an instruction that will enter E is queued for WB.
  task automatic drv(input logic v, input logic we, input logic dwe, input logic rs,
                     input logic d2, input logic [2:0] alu, input logic of,
                     input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs1,
                     input logic [RA_W-1:0] rs2, input bit enter);
    bus.validD            = v;
    bus.writeEnableDD     = we;
    bus.writeDataEnableMD = dwe;
    bus.resultSelectorWBD = rs;
    bus.data2SelectorED   = d2;
    bus.aluControlED      = alu;
    bus.outFlag           = of;
    bus.rdD               = rd;
    bus.rs1D              = rs1;
    bus.rs2D              = rs2;
    if (enter && v) sb_q.push_back('{we: we, rs: rs & we, rd: rd});
  endtask

  task automatic nop();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // WB monitor: pop on every newly loaded valid WB entry, track the count.
  initial begin : mon
    logic  pv, ps;
    wexp_t e;
    forever begin
      @(negedge clk);
      pv = bus.validW;
      ps = bus.stallIn;
      @(posedge clk);
      #2;
      if (mon_en && rst) begin
        if (!ps && pv) exp_cnt = exp_cnt + CNT_W'(1);
        if (!ps && bus.validW) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            chk("wb_retire", {bus.writeEnableW, bus.resultSelectorW, bus.rdW}, {e.we, e.rs, e.rd});
          end
        end
        chk("retired_count", bus.retiredCount, exp_cnt);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1);
  end

  initial begin : main
    logic [RA_W-1:0] lrd, r1, r2;
    bit              hz;

    rst         = 1'b0;
    mon_en      = 1'b0;
    exp_cnt     = '0;
    bus.stallIn = 1'b0;
    bus.flushIn = 1'b0;
    nop();
    repeat (2) cyc();
    chk("reset_outputs", all_vec(), 64'd0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Basic latency: E, M, WB on consecutive edges, count one edge later.
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 4'd5, '0, '0, 1'b1);
    cyc();
    chk("t1_e", e_vec(), 13'b1_111_1_0_0_0_0101_1);
    nop();
    cyc();
    chk("t1_m", m_vec(), 9'b1_0_0_0_0101_1);
    chk("t1_e_empty", bus.validE, 1'b0);
    cyc();
    chk("t1_w", w_vec(), 7'b1_0_0101_1);
    cyc();
    chk("t1_count", bus.retiredCount, 64'd1);

    // Don't-care masking of resultSelector and data2Selector.
    drv(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 1'b1, 4'd9, '0, '0, 1'b1);
    cyc();
    chk("mask_rs", e_vec(), 13'b1_011_0_1_0_1_1001_1);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 4'd2, '0, '0, 1'b0);
    cyc();
    chk("mask_d2", e_vec(), 13'b0_000_1_0_1_0_0010_0);
    nop();
    repeat (3) cyc();

    // Global stall holds every stage and the counter; flush is ignored meanwhile.
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd1, '0, '0, 1'b1);
    cyc();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd2, '0, '0, 1'b1);
    cyc();
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd3, '0, '0, 1'b1);
    cyc();
    chk("pre_stall_rd", {bus.rdE, bus.rdM, bus.rdW}, 12'h321);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd4, '0, '0, 1'b1);
    bus.stallIn = 1'b1;
    cyc();
    chk("stall1_rd", {bus.rdE, bus.rdM, bus.rdW}, 12'h321);
    chk("stall1_count", bus.retiredCount, 64'd2);
    bus.flushIn = 1'b1;
    cyc();
    chk("stall2_rd", {bus.rdE, bus.rdM, bus.rdW}, 12'h321);
    chk("stall2_valid", {bus.validE, bus.validM, bus.validW}, 3'b111);
    chk("stall2_count", bus.retiredCount, 64'd2);
    bus.stallIn = 1'b0;
    bus.flushIn = 1'b0;
    cyc();
    chk("resume_rd", {bus.rdE, bus.rdM, bus.rdW}, 12'h432);
    chk("resume_count", bus.retiredCount, 64'd3);

    // Branch flush kills D; M and WB keep advancing.
    drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b101, 1'b1, 4'd6, '0, '0, 1'b0);
    bus.flushIn = 1'b1;
    #1;
    chk("flush_stall_d", bus.stallD, 1'b0);
    cyc();
    chk("flush_e", e_vec(), 13'd0);
    chk("flush_mw_rd", {bus.rdM, bus.rdW, bus.validM, bus.validW}, 10'b0100_0011_1_1);
    chk("flush_count", bus.retiredCount, 64'd4);
    bus.flushIn = 1'b0;
    nop();
    repeat (3) cyc();

    // Load-use: rs1 match, rs2 match, no match.
    for (int k = 0; k < 3; k++) begin
      lrd = (k == 1) ? 4'd2 : 4'd3;
      r1  = (k == 0) ? 4'd3 : 4'd4;
      r2  = (k == 1) ? 4'd2 : 4'd5;
      hz  = HZ && (k < 2);
      drv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, lrd, '0, '0, 1'b1);
      cyc();
      drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 4'd7, r1, r2, !hz);
      #1;
      chk("hz_stall_d", bus.stallD, hz);
      cyc();
      if (hz) begin
        chk("hz_e_bubble", bus.validE, 1'b0);
        chk("hz_stall_clear", bus.stallD, 1'b0);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 4'd7, r1, r2, 1'b1);
        cyc();
      end
      chk("hz_d_enters", {bus.validE, bus.rdE, bus.data2SelectorE}, {1'b1, 4'd7, 1'b1});
      nop();
      repeat (3) cyc();
    end

    // Asynchronous reset mid-stream, between clock edges.
    for (int i = 1; i <= 5; i++) begin
      drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, RA_W'(i), '0, '0, 1'b1);
      cyc();
    end
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_all", all_vec(), 64'd0);
    sb_q.delete();
    exp_cnt = '0;
    nop();
    @(negedge clk);
    #2;
    rst = 1'b1;
    cyc();
    chk("post_reset_all", all_vec(), 64'd0);
    mon_en = 1'b1;

    // Restart with 16 back-to-back retirements: 4-bit count returns to 0.
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 1'b1, 1'b0, i[0], 1'b0, 3'd0, 1'b0, RA_W'(i), '0, '0, 1'b1);
      cyc();
    end
    nop();
    repeat (4) cyc();
    chk("wrap_count", bus.retiredCount, 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
